// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings for the EX stage.
//   ALUOp and funct encodings, WB/M control bit indices, the multiplier FSM
//   state enum, the EX/MEM register payload and an ALU operation decoder.
package pipe_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam int unsigned WB_REGWRITE = 1;
    localparam int unsigned WB_MEMTOREG = 0;
    localparam int unsigned M_MEMWRITE  = 1;
    localparam int unsigned M_MEMREAD   = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_MUL = 3'd5
    } alu_op_e;

    // EX/MEM pipeline register payload
    typedef struct packed {
        logic [1:0]        wb;
        logic [1:0]        m;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   wdata;
    } ex_mem_t;

    // Map ALUOp/funct onto an ALU operation; unknown funct falls back to add
    function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_SUB: op = ALU_SUB;
            ALUOP_OR:  op = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_SUB: op = ALU_SUB;
                    FUNCT_AND: op = ALU_AND;
                    FUNCT_OR:  op = ALU_OR;
                    FUNCT_SLT: op = ALU_SLT;
                    FUNCT_MUL: op = ALU_MUL;
                    default:   op = ALU_ADD;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add 32x32 multiplier (low 32 bits kept).
//   clk_i, rst_i      : clock, async active-high reset
//   start_i           : multiply request, accepted only in IDLE
//   a_i, b_i          : multiplicand / multiplier, sampled on acceptance
//   busy_o            : combinational; high in the accept cycle and in BUSY
//   done_o            : high for the single DONE cycle
//   product_o         : accumulator, valid while done_o is high
module seq_multiplier
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] product_o
);

    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and shift-add step
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            MUL_IDLE: begin
                if (start_i) begin
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    assign busy_o    = ((state_q == MUL_IDLE) && start_i) || (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = acc_q;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage with operand forwarding, ALU, multi-cycle
// multiply and the EX/MEM pipeline register.
//   ID/EX inputs  : WB_i, M_i, ALUSrc_i, ALUOp_i, RegDst_i, RS/RT/RDaddr_i,
//                   RSdata_i, RTdata_i, imm_i (imm_i[5:0] is funct)
//   MEM/WB fwd    : WBfwd_RegWrite_i, WBfwd_RDaddr_i, WBfwd_data_i
//   stall_o       : combinational back-pressure while a multiply runs
//   EX/MEM outputs: WB_o, M_o, ALUresult_o, MemWdata_o, RDaddr_o (registered)
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        M_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              RegDst_i,
    input  logic [REG_AW-1:0] RSaddr_i,
    input  logic [REG_AW-1:0] RTaddr_i,
    input  logic [REG_AW-1:0] RDaddr_i,
    input  logic [XLEN-1:0]   RSdata_i,
    input  logic [XLEN-1:0]   RTdata_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              WBfwd_RegWrite_i,
    input  logic [REG_AW-1:0] WBfwd_RDaddr_i,
    input  logic [XLEN-1:0]   WBfwd_data_i,
    output logic              stall_o,
    output logic [1:0]        WB_o,
    output logic [1:0]        M_o,
    output logic [XLEN-1:0]   ALUresult_o,
    output logic [XLEN-1:0]   MemWdata_o,
    output logic [REG_AW-1:0] RDaddr_o
);

    ex_mem_t ex_mem_q, ex_mem_d;

    alu_op_e           alu_op_c;
    logic              mul_dec_c;
    logic [XLEN-1:0]   op_a_c, fwd_rt_c, op_b_c, alu_res_c;
    logic [REG_AW-1:0] dest_c;
    logic              mul_busy, mul_done;
    logic [XLEN-1:0]   mul_product;

    // EX/MEM result first, then MEM/WB, then register file; r0 never forwards
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_data,
        input ex_mem_t           exm,
        input logic              wb_we,
        input logic [REG_AW-1:0] wb_rd,
        input logic [XLEN-1:0]   wb_data
    );
        logic [XLEN-1:0] v;
        v = rf_data;
        if (exm.wb[WB_REGWRITE] && (exm.rd != '0) && (exm.rd == addr)) begin
            v = exm.result;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == addr)) begin
            v = wb_data;
        end
        return v;
    endfunction

    assign alu_op_c  = decode_alu(ALUOp_i, imm_i[5:0]);
    assign mul_dec_c = (alu_op_c == ALU_MUL);
    assign dest_c    = RegDst_i ? RDaddr_i : RTaddr_i;
    assign op_a_c    = fwd_select(RSaddr_i, RSdata_i, ex_mem_q,
                                  WBfwd_RegWrite_i, WBfwd_RDaddr_i, WBfwd_data_i);
    assign fwd_rt_c  = fwd_select(RTaddr_i, RTdata_i, ex_mem_q,
                                  WBfwd_RegWrite_i, WBfwd_RDaddr_i, WBfwd_data_i);
    assign op_b_c    = ALUSrc_i ? imm_i : fwd_rt_c;

    // Single-cycle ALU; multiply is handled by the sequential unit
    always_comb begin
        alu_res_c = op_a_c + op_b_c;
        case (alu_op_c)
            ALU_SUB: alu_res_c = op_a_c - op_b_c;
            ALU_AND: alu_res_c = op_a_c & op_b_c;
            ALU_OR:  alu_res_c = op_a_c | op_b_c;
            ALU_SLT: alu_res_c = XLEN'($signed(op_a_c) < $signed(op_b_c));
            default: alu_res_c = op_a_c + op_b_c;
        endcase
    end

    seq_multiplier #(
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_dec_c),
        .a_i       (op_a_c),
        .b_i       (op_b_c),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign stall_o = !rst_i && mul_busy;

    // EX/MEM next value: bubble while stalled, product in DONE, else ALU
    always_comb begin
        ex_mem_d = '0;
        if (!stall_o) begin
            ex_mem_d.wb     = WB_i;
            ex_mem_d.m      = M_i;
            ex_mem_d.rd     = dest_c;
            ex_mem_d.wdata  = fwd_rt_c;
            ex_mem_d.result = mul_done ? mul_product : alu_res_c;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign WB_o        = ex_mem_q.wb;
    assign M_o         = ex_mem_q.m;
    assign RDaddr_o    = ex_mem_q.rd;
    assign ALUresult_o = ex_mem_q.result;
    assign MemWdata_o  = ex_mem_q.wdata;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage against a
// behavioural model of the EX/MEM register contents.
module tb_ex_mem_stage;

    localparam int MUL_CYCLES = 32;

    logic        clk_i, rst_i;
    logic [1:0]  WB_i, M_i, ALUOp_i;
    logic        ALUSrc_i, RegDst_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic [31:0] RSdata_i, RTdata_i, imm_i;
    logic        WBfwd_RegWrite_i;
    logic [4:0]  WBfwd_RDaddr_i;
    logic [31:0] WBfwd_data_i;
    logic        stall_o;
    logic [1:0]  WB_o, M_o;
    logic [31:0] ALUresult_o, MemWdata_o;
    logic [4:0]  RDaddr_o;

    ex_mem_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i),
        .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i), .RegDst_i(RegDst_i),
        .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i),
        .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i),
        .WBfwd_RegWrite_i(WBfwd_RegWrite_i), .WBfwd_RDaddr_i(WBfwd_RDaddr_i),
        .WBfwd_data_i(WBfwd_data_i), .stall_o(stall_o), .WB_o(WB_o), .M_o(M_o),
        .ALUresult_o(ALUresult_o), .MemWdata_o(MemWdata_o), .RDaddr_o(RDaddr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  wb, m, aluop;
        logic        alusrc, regdst;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
    } instr_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected EX/MEM contents
    logic [1:0]  m_wb, m_m;
    logic [4:0]  m_rd;
    logic [31:0] m_res, m_wd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".wb"},  32'(WB_o),     32'(m_wb));
        check_eq({tag, ".m"},   32'(M_o),      32'(m_m));
        check_eq({tag, ".rd"},  32'(RDaddr_o), 32'(m_rd));
        check_eq({tag, ".res"}, ALUresult_o,   m_res);
        check_eq({tag, ".wd"},  MemWdata_o,    m_wd);
    endtask

    task automatic model_clear();
        m_wb = 2'b00; m_m = 2'b00; m_rd = 5'd0; m_res = 32'd0; m_wd = 32'd0;
    endtask

    task automatic set_wbf(input logic we, input logic [4:0] rd, input logic [31:0] d);
        WBfwd_RegWrite_i = we; WBfwd_RDaddr_i = rd; WBfwd_data_i = d;
    endtask

    task automatic rand_wbf();
        set_wbf(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic drive(input instr_t i);
        WB_i = i.wb; M_i = i.m; ALUSrc_i = i.alusrc; ALUOp_i = i.aluop;
        RegDst_i = i.regdst; RSaddr_i = i.rs; RTaddr_i = i.rt; RDaddr_i = i.rd;
        RSdata_i = i.rsd; RTdata_i = i.rtd; imm_i = i.imm;
    endtask

    // Value an operand register should resolve to, from model state and MEM/WB
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
        if (m_wb[1] && m_rd != 5'd0 && m_rd == a) return m_res;
        if (WBfwd_RegWrite_i && WBfwd_RDaddr_i != 5'd0 && WBfwd_RDaddr_i == a) return WBfwd_data_i;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b11: return a | b;
            default: begin
                case (f)
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: return a + b;
                endcase
            end
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 (or mid-cycle in reset if aborted)
    task automatic issue(input instr_t i, input int abort_at, input bit rand_fwd,
                         output int stall_cnt);
        logic [31:0] a, rt, b, prod;
        logic [4:0]  dest;
        bit          is_mul;
        stall_cnt = 0;
        drive(i);
        is_mul = (i.aluop == 2'b10) && (i.imm[5:0] == 6'h18);
        a    = fwd(i.rs, i.rsd);
        rt   = fwd(i.rt, i.rtd);
        b    = i.alusrc ? i.imm : rt;
        dest = i.regdst ? i.rd : i.rt;
        if (!is_mul) begin
            @(negedge clk_i);
            check_eq("stall_alu", 32'(stall_o), 32'd0);
            @(posedge clk_i); #1;
            m_wb = i.wb; m_m = i.m; m_rd = dest; m_res = alu_ref(i.aluop, i.imm[5:0], a, b); m_wd = rt;
            check_outputs("alu");
            return;
        end
        prod = a * b;
        for (int k = 0; k <= MUL_CYCLES; k++) begin
            if (k > 0 && rand_fwd) rand_wbf();
            @(negedge clk_i);
            if (stall_o) stall_cnt++;
            check_eq("stall_mul", 32'(stall_o), 32'd1);
            if (k == abort_at) begin
                rst_i = 1'b1;
                #1;
                model_clear();
                check_eq("stall_rst", 32'(stall_o), 32'd0);
                check_outputs("rst_mid");
                return;
            end
            @(posedge clk_i); #1;
            model_clear();
            check_outputs("bubble");
        end
        if (rand_fwd) rand_wbf();
        rt = fwd(i.rt, i.rtd);
        @(negedge clk_i);
        check_eq("stall_done", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        m_wb = i.wb; m_m = i.m; m_rd = dest; m_res = prod; m_wd = rt;
        check_outputs("mul");
    endtask

    function automatic instr_t rand_instr(input bit allow_mul);
        instr_t i;
        logic [5:0] fl [7];
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25;
        fl[4] = 6'h2A; fl[5] = 6'($urandom); fl[6] = 6'h20;
        i.wb = 2'($urandom); i.m = 2'($urandom); i.aluop = 2'($urandom);
        i.alusrc = 1'($urandom); i.regdst = 1'($urandom);
        i.rs = 5'($urandom_range(0, 7)); i.rt = 5'($urandom_range(0, 7));
        i.rd = 5'($urandom_range(0, 7));
        i.rsd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        i.rtd = $urandom;
        i.imm = $urandom;
        if (i.aluop == 2'b10) i.imm[5:0] = fl[$urandom_range(0, 6)];
        if (i.aluop == 2'b10 && i.imm[5:0] == 6'h18 && !allow_mul) i.imm[5:0] = 6'h20;
        if (allow_mul && $urandom_range(0, 9) == 0) begin
            i.aluop = 2'b10; i.alusrc = 1'b0; i.imm[5:0] = 6'h18;
        end
        return i;
    endfunction

    function automatic instr_t mk(input logic [1:0] wb, input logic [1:0] m,
                                  input logic [1:0] aluop, input logic alusrc,
                                  input logic regdst, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic [31:0] imm);
        instr_t i;
        i.wb = wb; i.m = m; i.aluop = aluop; i.alusrc = alusrc; i.regdst = regdst;
        i.rs = rs; i.rt = rt; i.rd = rd; i.rsd = rsd; i.rtd = rtd; i.imm = imm;
        return i;
    endfunction

    initial begin
        int sc;
        rst_i = 1'b1;
        drive(mk(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
        set_wbf(1'b0, 5'd0, 32'd0);
        model_clear();
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("reset_stall", 32'(stall_o), 32'd0);
        check_outputs("reset");
        rst_i = 1'b0;

        // add, no hazard
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h20), -1, 1'b0, sc);
        check_eq("add_res", ALUresult_o, 32'd12);
        check_eq("add_rd", 32'(RDaddr_o), 32'd3);
        check_eq("add_wb", 32'(WB_o), 32'd2);

        // EX/MEM forward beats MEM/WB
        set_wbf(1'b1, 5'd3, 32'd99);
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd2, 32'h22), -1, 1'b0, sc);
        check_eq("fwd_exmem", ALUresult_o, 32'd10);

        // destination r0 never forwards
        set_wbf(1'b0, 5'd0, 32'd0);
        issue(mk(2'b10, 2'b00, 2'b00, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 32'd0), -1, 1'b0, sc);
        set_wbf(1'b1, 5'd0, 32'd99);
        issue(mk(2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 5'd0, 5'd1, 5'd7, 32'd50, 32'd2, 32'd0), -1, 1'b0, sc);
        check_eq("fwd_r0", ALUresult_o, 32'd48);

        // lw then sw with store data forwarded from EX/MEM
        set_wbf(1'b0, 5'd0, 32'd0);
        issue(mk(2'b11, 2'b01, 2'b00, 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 32'h100, 32'd0, 32'hFFFF_FFFC), -1, 1'b0, sc);
        check_eq("lw_addr", ALUresult_o, 32'hFC);
        check_eq("lw_rd", 32'(RDaddr_o), 32'd6);
        issue(mk(2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 32'h100, 32'hDEAD, 32'd8), -1, 1'b0, sc);
        check_eq("sw_addr", ALUresult_o, 32'h108);
        check_eq("sw_wdata", MemWdata_o, 32'hFC);

        // slt signed
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd8, 5'd9, 5'd10, 32'hFFFF_FFFF, 32'd1, 32'h2A), -1, 1'b0, sc);
        check_eq("slt", ALUresult_o, 32'd1);

        // multiplies
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd11, 5'd12, 5'd13, 32'h10001, 32'd3, 32'h18), -1, 1'b0, sc);
        check_eq("mul_res", ALUresult_o, 32'h30003);
        check_eq("mul_stall_cycles", 32'(sc), 32'(MUL_CYCLES + 1));
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd14, 5'd15, 5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h18), -1, 1'b1, sc);
        check_eq("mul_max", ALUresult_o, 32'd1);

        // reset at BUSY count 10, then a fresh multiply
        set_wbf(1'b0, 5'd0, 32'd0);
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd77, 32'd88, 32'h18), 11, 1'b0, sc);
        @(posedge clk_i); #1;
        check_outputs("rst_hold");
        rst_i = 1'b0;
        issue(mk(2'b10, 2'b00, 2'b10, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd1234, 32'd5678, 32'h18), -1, 1'b0, sc);
        check_eq("mul_after_rst", ALUresult_o, 32'd7006652);

        // randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            rand_wbf();
            issue(rand_instr(1'b1), -1, 1'b1, sc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage plus EX/MEM pipeline register for the 5-stage pipeline. Consumes the decoded fields held in the ID/EX register. Resolves operand forwarding, performs ALU operations and a multi-cycle 32×32 multiply, and registers the result and control for the MEM stage. While a multiply is in progress it back-pressures ID/EX and upstream via `stall_o`.

## Interface
Parameters:
- `MUL_CYCLES`, 32: iterations of the shift-add multiplier; legal range 1..32.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `WB_i` in 2: WB control from ID/EX; [1] RegWrite, [0] MemtoReg.
- `M_i` in 2: MEM control; [1] MemWrite, [0] MemRead.
- `ALUSrc_i` in 1: 1 selects immediate as operand B.
- `ALUOp_i` in 2: 00 add, 01 sub, 10 R-type (decode funct), 11 or.
- `RegDst_i` in 1: 1 selects RD, 0 selects RT as destination.
- `RSaddr_i`, `RTaddr_i`, `RDaddr_i` in 5: register addresses.
- `RSdata_i`, `RTdata_i` in 32: register-file operands.
- `imm_i` in 32: sign-extended immediate; [5:0] is funct.
- `WBfwd_RegWrite_i` in 1: MEM/WB RegWrite.
- `WBfwd_RDaddr_i` in 5: MEM/WB destination.
- `WBfwd_data_i` in 32: MEM/WB write-back value.
- `stall_o` out 1: freeze PC, IF/ID, ID/EX.
- `WB_o` out 2, `M_o` out 2: registered control to MEM.
- `ALUresult_o` out 32: registered ALU/multiply result.
- `MemWdata_o` out 32: registered forwarded RT value (store data).
- `RDaddr_o` out 5: registered destination register.

## Operation
- **Funct decode (ALUOp=10).** 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed, result 0/1), 011000 mul. Any other funct produces add.
- **Forwarding, per operand A (RS) and B-source (RT):**
  - Priority 1: if `WB_o[1]` and `RDaddr_o`≠0 and it equals the address, use `ALUresult_o`.
  - Priority 2: else if `WBfwd_RegWrite_i` and `WBfwd_RDaddr_i`≠0 and match, use `WBfwd_data_i`.
  - Otherwise use the register-file value.
  - Operand B is `imm_i` if `ALUSrc_i`, else forwarded RT.
  - `MemWdata_o` always takes forwarded RT.
- **Arithmetic.** All 32-bit, wrap-around, no overflow flag. mul keeps the low 32 bits of the unsigned product.
- **Multiply FSM.**
  - IDLE: if mul is decoded, `stall_o`=1, latch operand A into the multiplicand and operand B into the multiplier, clear the accumulator and counter, go to BUSY.
  - BUSY: each cycle, if multiplier[0] add multiplicand to the accumulator; shift multiplicand left 1 and multiplier right 1; counter++. When counter==`MUL_CYCLES`-1, go to DONE. `stall_o`=1.
  - DONE: `stall_o`=0. EX/MEM captures the accumulator plus the mul instruction's WB/M/dest. Go to IDLE.
- **EX/MEM register.**
  - Loads every cycle.
  - While `stall_o`=1 it loads a bubble: WB=0, M=0, RDaddr=0, data=0.
  - Otherwise it loads the current instruction's result.

## Timing
- **Non-mul instructions:** 1-cycle latency; result visible on `ALUresult_o` after the next rising edge.
- **mul:** occupies EX for `MUL_CYCLES`+2 cycles. `stall_o` is high for `MUL_CYCLES`+1 cycles, starting combinationally in the cycle the mul enters EX. The result appears after the edge that ends DONE.
- **Stall lifetime.** `stall_o` is a combinational function of the FSM state and the decode. It is forced to 0 while `rst_i`=1.
- **Reset.** Any reset, including mid-multiply, immediately (asynchronously) sets all registered outputs to 0 and the FSM to IDLE. The partial product is discarded.
- **Forwarding across a multiply.** Forwarded operands are sampled only in the IDLE capture cycle. Changes on `WBfwd_*` during BUSY are ignored.
- **Back-to-back muls.** DONE→IDLE, then the next mul is detected in IDLE on the following cycle. There is no overlap.
- **Zero register.** A destination of 0 never forwards, even when RegWrite=1.

## Structure
- **Shared package `pipe_pkg`:** ALUOp encodings, funct constants (`FUNCT_ADD`, `FUNCT_MUL`, …), FSM state enum (IDLE/BUSY/DONE), WB/M bit-index constants.
- **Sub-module `seq_multiplier`:** FSM, counter and shift-add datapath, with a start/busy/done handshake and a 32-bit product.
- **Top level:** forwarding, ALU and the EX/MEM register.

## Test plan
- **Add with no hazard.** RS=5, RT=7, ALUOp=10, funct=100000, RD=3, WB=10 → next edge: `ALUresult_o`=12, `RDaddr_o`=3, `WB_o`=10.
- **EX/MEM forward beats MEM/WB.** Previous result 12 to r3; MEM/WB also writes r3=99; next sub r3−r1 with r1=2 → 10. Same test with RD=0 → register-file value is used.
- **lw/sw.** ALUSrc=1, imm=−4, RS=0x100 → 0xFC. sw: `MemWdata_o` equals the forwarded RT.
- **slt signed.** slt with 0xFFFFFFFF vs 1 → 1.
- **mul 0x10001 × 0x3.** Result 0x30003.
  - `stall_o` is high for exactly 33 cycles.
  - Bubbles (`WB_o`=0, `M_o`=0) are output during the stall.
  - A max-operand check 0xFFFFFFFF×0xFFFFFFFF gives low word 0x00000001.
- **Reset mid-multiply.** Assert `rst_i` at BUSY count 10 → `stall_o`=0 and all outputs 0 immediately. After release, a new mul completes correctly.
